// File: rtl/riscv_mem_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package riscv_mem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int MASK_W     = DEF_DATA_W / 8;

    // Tags which port owns the read whose data arrives this cycle.
    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_IF   = 2'd1,
        RD_DM   = 2'd2
    } rd_tag_t;

endpackage

// File: rtl/riscv_arb_wait_cnt.sv
// Saturating counter of consecutive cycles that fetch was denied.
module riscv_arb_wait_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [3:0] cnt;

    // Clear wins over increment; hold once the limit is reached.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            cnt <= 4'd0;
        else if (clr)
            cnt <= 4'd0;
        else if (inc && cnt != 4'(MAX_WAIT))
            cnt <= cnt + 4'd1;
    end

    assign sat = (cnt == 4'(MAX_WAIT));

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port synchronous RAM between fetch and data ports.
// Data has priority; fetch wins once it has been denied MAX_WAIT cycles.
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  if_req_in,
    input  logic [ADDR_W-1:0]     if_addr_in,
    output logic                  if_gnt_out,
    output logic                  if_rvalid_out,
    output logic [DATA_W-1:0]     if_rdata_out,
    input  logic                  dm_req_in,
    input  logic                  dm_we_in,
    input  logic [ADDR_W-1:0]     dm_addr_in,
    input  logic [DATA_W-1:0]     dm_wdata_in,
    input  logic [DATA_W/8-1:0]   dm_mask_in,
    output logic                  dm_gnt_out,
    output logic                  dm_rvalid_out,
    output logic [DATA_W-1:0]     dm_rdata_out,
    output logic                  mem_en_out,
    output logic                  mem_we_out,
    output logic [ADDR_W-1:0]     mem_addr_out,
    output logic [DATA_W-1:0]     mem_wdata_out,
    output logic [DATA_W/8-1:0]   mem_mask_out,
    input  logic [DATA_W-1:0]     mem_rdata_in
);

    logic    wait_sat;
    logic    if_win;
    logic    dm_win;
    rd_tag_t state_q;
    rd_tag_t state_d;

    // Grants are forced low while reset is held.
    assign if_win = !rst_in && if_req_in && (!dm_req_in || wait_sat);
    assign dm_win = !rst_in && dm_req_in && !(if_req_in && wait_sat);

    assign if_gnt_out = if_win;
    assign dm_gnt_out = dm_win;

    riscv_arb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wait_cnt (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .inc    (if_req_in && !if_win),
        .clr    (if_win || !if_req_in),
        .sat    (wait_sat)
    );

    // Route the winner onto the memory bus; idle bus is all zeros.
    always_comb begin
        mem_en_out    = 1'b0;
        mem_we_out    = 1'b0;
        mem_addr_out  = '0;
        mem_wdata_out = '0;
        mem_mask_out  = '0;
        if (dm_win) begin
            mem_en_out    = 1'b1;
            mem_we_out    = dm_we_in;
            mem_addr_out  = dm_addr_in;
            mem_wdata_out = dm_wdata_in;
            mem_mask_out  = dm_we_in ? dm_mask_in : '0;
        end else if (if_win) begin
            mem_en_out   = 1'b1;
            mem_addr_out = if_addr_in;
        end
    end

    // Read-tag register; reset discards any read in flight.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            state_q <= RD_IDLE;
        else
            state_q <= state_d;
    end

    // Next tag depends only on this cycle's grant, so reads can issue back to back.
    always_comb begin
        state_d = RD_IDLE;
        if (if_win)
            state_d = RD_IF;
        else if (dm_win && !dm_we_in)
            state_d = RD_DM;
    end

    assign if_rvalid_out = (state_q == RD_IF);
    assign dm_rvalid_out = (state_q == RD_DM);
    assign if_rdata_out  = if_rvalid_out ? mem_rdata_in : '0;
    assign dm_rdata_out  = dm_rvalid_out ? mem_rdata_in : '0;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: a behavioural RAM, a scoreboard
// queue filled at grant time and a monitor that pops on every rvalid.
module tb_riscv_mem_arbiter;
    import riscv_mem_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          if_req_in;
    logic [AW-1:0] if_addr_in;
    logic          if_gnt_out, if_rvalid_out;
    logic [DW-1:0] if_rdata_out;
    logic          dm_req_in, dm_we_in;
    logic [AW-1:0] dm_addr_in;
    logic [DW-1:0] dm_wdata_in;
    logic [MASK_W-1:0] dm_mask_in;
    logic          dm_gnt_out, dm_rvalid_out;
    logic [DW-1:0] dm_rdata_out;
    logic          mem_en_out, mem_we_out;
    logic [AW-1:0] mem_addr_out;
    logic [DW-1:0] mem_wdata_out;
    logic [MASK_W-1:0] mem_mask_out;
    logic [DW-1:0] mem_rdata_in;

    riscv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_gnt_out(if_gnt_out),
        .if_rvalid_out(if_rvalid_out), .if_rdata_out(if_rdata_out),
        .dm_req_in(dm_req_in), .dm_we_in(dm_we_in), .dm_addr_in(dm_addr_in),
        .dm_wdata_in(dm_wdata_in), .dm_mask_in(dm_mask_in), .dm_gnt_out(dm_gnt_out),
        .dm_rvalid_out(dm_rvalid_out), .dm_rdata_out(dm_rdata_out),
        .mem_en_out(mem_en_out), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
        .mem_wdata_out(mem_wdata_out), .mem_mask_out(mem_mask_out),
        .mem_rdata_in(mem_rdata_in)
    );

    always #5 clk_in = ~clk_in;

    // Behavioural single-port RAM, word addressed, one-cycle read latency.
    logic [DW-1:0] ram [0:255];
    always @(posedge clk_in) begin
        if (mem_en_out && mem_we_out) begin
            for (int b = 0; b < MASK_W; b++)
                if (mem_mask_out[b]) ram[mem_addr_out[9:2]][8*b +: 8] <= mem_wdata_out[8*b +: 8];
        end else if (mem_en_out) begin
            mem_rdata_in <= ram[mem_addr_out[9:2]];
        end
    end

    typedef struct {
        logic          is_dm;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        if_req_in = 0; if_addr_in = '0;
        dm_req_in = 0; dm_we_in = 0; dm_addr_in = '0; dm_wdata_in = '0; dm_mask_in = '0;
    endtask

    task automatic push(input logic is_dm, input logic [DW-1:0] d);
        exp_t e;
        e.is_dm = is_dm;
        e.data  = d;
        sb_q.push_back(e);
    endtask

    // Monitor: every rvalid must match the oldest expected read.
    always @(negedge clk_in) begin
        if (!rst_in && (if_rvalid_out || dm_rvalid_out)) begin
            if (if_rvalid_out && dm_rvalid_out) begin
                chk("rvalid_both", 2'b11, 2'b01);
            end else if (sb_q.size() == 0) begin
                chk("rvalid_unexpected", {if_rvalid_out, dm_rvalid_out}, 2'b00);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_port", dm_rvalid_out, e.is_dm);
                chk("sb_data", dm_rvalid_out ? dm_rdata_out : if_rdata_out, e.data);
                chk("sb_other_zero", dm_rvalid_out ? if_rdata_out : dm_rdata_out, '0);
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = '0;
        ram[4]  = 32'h00d60e33;   // 0x10
        ram[5]  = 32'h12345678;   // 0x14
        ram[8]  = 32'hCAFE0123;   // 0x20
        mem_rdata_in = '0;

        // 1: reset with random inputs -> all outputs zero
        rst_in = 1;
        for (int k = 0; k < 2; k++) begin
            if_req_in = 1'($urandom); if_addr_in = $urandom;
            dm_req_in = 1'($urandom); dm_we_in = 1'($urandom); dm_addr_in = $urandom;
            dm_wdata_in = $urandom; dm_mask_in = MASK_W'($urandom);
            @(negedge clk_in);
            chk("reset_ctrl", {if_gnt_out, dm_gnt_out, if_rvalid_out, dm_rvalid_out, mem_en_out, mem_we_out}, '0);
            chk("reset_bus", {mem_addr_out, mem_wdata_out, mem_mask_out, if_rdata_out, dm_rdata_out}, '0);
        end
        tick();
        rst_in = 0;
        idle();
        @(negedge clk_in);
        chk("idle", {mem_en_out, if_rvalid_out, dm_rvalid_out, mem_addr_out}, '0);

        // 2: fetch only
        tick();
        if_req_in = 1; if_addr_in = 32'h10;
        @(negedge clk_in);
        chk("t2_gnt", {if_gnt_out, dm_gnt_out, mem_en_out, mem_we_out}, 4'b1010);
        chk("t2_bus", {mem_addr_out, mem_mask_out}, {32'h10, 4'h0});
        push(0, 32'h00d60e33);
        tick();
        idle();
        @(negedge clk_in);
        chk("t2_rvalid", if_rvalid_out, 1'b1);

        // 3: both request; data read first, fetch next cycle
        tick();
        if_req_in = 1; if_addr_in = 32'h14;
        dm_req_in = 1; dm_addr_in = 32'h20;
        @(negedge clk_in);
        chk("t3_gnt0", {if_gnt_out, dm_gnt_out, mem_addr_out}, {2'b01, 32'h20});
        push(1, 32'hCAFE0123);
        tick();
        dm_req_in = 0;
        @(negedge clk_in);
        chk("t3_gnt1", {if_gnt_out, dm_gnt_out, mem_addr_out, dm_rvalid_out}, {2'b10, 32'h14, 1'b1});
        push(0, 32'h12345678);
        tick();
        idle();
        @(negedge clk_in);
        chk("t3_if_rvalid", {if_rvalid_out, dm_rvalid_out}, 2'b10);

        // 4: starvation guard, data held 6 cycles, fetch wins on 5th
        tick();
        if_req_in = 1; if_addr_in = 32'h10;
        dm_req_in = 1; dm_addr_in = 32'h20; dm_mask_in = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            chk($sformatf("t4_gnt%0d", i), {if_gnt_out, dm_gnt_out}, (i == 4) ? 2'b10 : 2'b01);
            if (i == 4) begin
                chk("t4_if_bus", {mem_we_out, mem_mask_out, mem_addr_out}, {1'b0, 4'h0, 32'h10});
                push(0, 32'h00d60e33);
            end else begin
                push(1, 32'hCAFE0123);
            end
            tick();
            if (i == 4) if_req_in = 0;
        end
        idle();

        // 5: masked write, then readback
        dm_req_in = 1; dm_we_in = 1; dm_addr_in = 32'h30;
        dm_wdata_in = 32'hDEADBEEF; dm_mask_in = 4'b0011;
        @(negedge clk_in);
        chk("t5_wr", {dm_gnt_out, mem_en_out, mem_we_out, mem_mask_out, mem_wdata_out},
            {3'b111, 4'b0011, 32'hDEADBEEF});
        tick();
        dm_we_in = 0; dm_mask_in = '0; dm_wdata_in = '0;
        @(negedge clk_in);
        chk("t5_no_rvalid", {if_rvalid_out, dm_rvalid_out}, 2'b00);
        chk("t5_rd_gnt", {dm_gnt_out, mem_we_out}, 2'b10);
        push(1, 32'h0000BEEF);
        tick();
        idle();

        // 6: reset right after a data read grant discards it
        tick();
        dm_req_in = 1; dm_addr_in = 32'h20;
        @(negedge clk_in);
        chk("t6_gnt", dm_gnt_out, 1'b1);
        tick();
        rst_in = 1;
        idle();
        @(negedge clk_in);
        chk("t6_no_rvalid", {dm_rvalid_out, dm_rdata_out}, '0);
        tick();
        rst_in = 0;
        @(negedge clk_in);
        chk("t6_post_idle", {dm_rvalid_out, if_rvalid_out}, 2'b00);
        tick();
        if_req_in = 1; if_addr_in = 32'h10;
        @(negedge clk_in);
        chk("t6_fetch_gnt", {if_gnt_out, mem_addr_out}, {1'b1, 32'h10});
        push(0, 32'h00d60e33);
        tick();
        idle();
        @(negedge clk_in);
        chk("t6_fetch_rvalid", if_rvalid_out, 1'b1);

        repeat (3) tick();
        chk("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
